// File: rtl/cond_unit.sv
// cond_unit -- conditional-execution unit between the decoder and the flags
// register / datapath write ports.
//
// Evaluates each instruction's 4-bit condition field against the current
// N,Z,C,V. If the condition passes, the decoder's write enables go through.
// The unit also drives the flags register write strobe.
//
// The flags register clears whichever half it does not write. Because of
// that, this unit keeps its own shadow copy of each half. An instruction
// that updates both halves is split into two writes: NZ first, then CV. The
// split costs one stall cycle.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   valid_in                  decoder presents an instruction this cycle
//   cond[3:0]                 condition field
//   flag_w_in[1:0]            requested flag update {NZ, CV}
//   reg_w_in/mem_w_in/pc_s_in ungated write enables from the decoder
//   flags_32[1:0]             flags register {N,Z}
//   flags_10[1:0]             flags register {C,V}
//   flag_w[1:0]               write strobe to the flags register {NZ, CV}
//   reg_w/mem_w/pc_s          gated write enables
//   cond_ex                   condition passed
//   ready                     low: decoder and ALU hold instruction/operands
module cond_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [3:0] cond,
  input  logic [1:0] flag_w_in,
  input  logic       reg_w_in,
  input  logic       mem_w_in,
  input  logic       pc_s_in,
  input  logic [1:0] flags_32,
  input  logic [1:0] flags_10,
  output logic [1:0] flag_w,
  output logic       reg_w,
  output logic       mem_w,
  output logic       pc_s,
  output logic       cond_ex,
  output logic       ready
);

  typedef enum logic {IDLE, SPLIT_CV} state_t;

  state_t     state, state_nxt;
  logic [1:0] sh_nz, sh_cv;
  logic       pend_nz, pend_cv;

  // The register half written last cycle is already valid at the register
  // outputs. The shadow only catches up one edge later, so bypass to the
  // register outputs while a capture is pending.
  logic [1:0] nz, cv;
  assign nz = pend_nz ? flags_32 : sh_nz;
  assign cv = pend_cv ? flags_10 : sh_cv;

  function automatic logic cond_pass(input logic [3:0] c, input logic n,
                                     input logic z, input logic cf,
                                     input logic v);
    case (c)
      4'h0: cond_pass = z;
      4'h1: cond_pass = !z;
      4'h2: cond_pass = cf;
      4'h3: cond_pass = !cf;
      4'h4: cond_pass = n;
      4'h5: cond_pass = !n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = !v;
      4'h8: cond_pass = cf & !z;
      4'h9: cond_pass = !cf | z;
      4'hA: cond_pass = (n == v);
      4'hB: cond_pass = (n != v);
      4'hC: cond_pass = !z & (n == v);
      4'hD: cond_pass = z | (n != v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  logic pass;
  assign pass = cond_pass(cond, nz[1], nz[0], cv[1], cv[0]);

  always_comb begin
    state_nxt = state;
    flag_w    = 2'b00;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    pc_s      = 1'b0;
    cond_ex   = 1'b0;
    ready     = 1'b1;
    // Outputs stay quiet while reset is held. This also drops a pending CV
    // write at once if reset hits mid-split.
    if (!rst) begin
      case (state)
        IDLE: begin
          cond_ex = valid_in & pass;
          if (cond_ex) begin
            reg_w = reg_w_in;
            mem_w = mem_w_in;
            pc_s  = pc_s_in;
            case (flag_w_in)
              2'b10:   flag_w = 2'b10;
              2'b01:   flag_w = 2'b01;
              2'b11: begin
                // NZ now, CV next cycle; the ALU holds its flags meanwhile
                flag_w    = 2'b10;
                ready     = 1'b0;
                state_nxt = SPLIT_CV;
              end
              default: flag_w = 2'b00;
            endcase
          end
        end
        SPLIT_CV: begin
          // Second half of a split. The enables already fired in the first
          // cycle, so the decoder inputs are ignored here.
          cond_ex   = 1'b1;
          flag_w    = 2'b01;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sh_nz   <= 2'b00;
      sh_cv   <= 2'b00;
      pend_nz <= 1'b0;
      pend_cv <= 1'b0;
    end else begin
      state   <= state_nxt;
      pend_nz <= (flag_w == 2'b10);
      pend_cv <= (flag_w == 2'b01);
      if (pend_nz) sh_nz <= flags_32;
      if (pend_cv) sh_cv <= flags_10;
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit. The stimulus process drives one directed
// vector per cycle and queues its hand-computed outputs. The monitor process
// pops one entry and compares it on each falling edge.
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic [3:0] cond;
  logic [1:0] flag_w_in;
  logic       reg_w_in, mem_w_in, pc_s_in;
  logic [1:0] flags_32, flags_10;
  logic [1:0] flag_w;
  logic       reg_w, mem_w, pc_s, cond_ex, ready;

  cond_unit dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .cond     (cond),
    .flag_w_in(flag_w_in),
    .reg_w_in (reg_w_in),
    .mem_w_in (mem_w_in),
    .pc_s_in  (pc_s_in),
    .flags_32 (flags_32),
    .flags_10 (flags_10),
    .flag_w   (flag_w),
    .reg_w    (reg_w),
    .mem_w    (mem_w),
    .pc_s     (pc_s),
    .cond_ex  (cond_ex),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  // expected = {flag_w[1:0], reg_w, mem_w, pc_s, cond_ex, ready}
  typedef struct {
    int         id;
    logic [6:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  passes = 0;

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t e;
      logic [6:0] got;
      e   = sb_q.pop_front();
      got = {flag_w, reg_w, mem_w, pc_s, cond_ex, ready};
      checks++;
      if (got === e.exp) passes++;
      else $display("FAIL step%0d {fw,rw,mw,ps,cex,rdy} got=%b want=%b",
                    e.id, got, e.exp);
    end
  end

  int step_id = 0;

  // en = {reg_w_in, mem_w_in, pc_s_in}
  task automatic step(input logic r, input logic v, input logic [3:0] c,
                      input logic [1:0] fw, input logic [2:0] en,
                      input logic [1:0] f32, input logic [1:0] f10,
                      input logic [6:0] exp);
    sb_t e;
    @(posedge clk);
    #1;
    rst       = r;
    valid_in  = v;
    cond      = c;
    flag_w_in = fw;
    {reg_w_in, mem_w_in, pc_s_in} = en;
    flags_32  = f32;
    flags_10  = f10;
    e.id  = step_id;
    e.exp = exp;
    sb_q.push_back(e);
    step_id++;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; cond = 4'h0; flag_w_in = 2'b00;
    reg_w_in = 1'b0; mem_w_in = 1'b0; pc_s_in = 1'b0;
    flags_32 = 2'b00; flags_10 = 2'b00;
    repeat (2) @(posedge clk);

    // outputs held quiet during reset even with a passing split request
    step(1, 1, 4'hE, 2'b11, 3'b111, 2'b11, 2'b11, 7'b00_000_0_1);
    // EQ with Z=0 in the shadow; the register shows Z=1 but no capture is pending
    step(0, 1, 4'h0, 2'b00, 3'b111, 2'b01, 2'b00, 7'b00_000_0_1);
    step(0, 1, 4'hE, 2'b00, 3'b101, 2'b01, 2'b00, 7'b00_101_1_1);
    // NZ write (ALU NZCV=0100); the next EQ sees Z=1 through the bypass
    step(0, 1, 4'hE, 2'b10, 3'b000, 2'b00, 2'b00, 7'b10_000_1_1);
    step(0, 1, 4'h0, 2'b00, 3'b100, 2'b01, 2'b00, 7'b00_100_1_1);
    // the shadow now holds NZ=01, regardless of the register outputs
    step(0, 1, 4'h0, 2'b00, 3'b010, 2'b00, 2'b00, 7'b00_010_1_1);
    step(0, 1, 4'h1, 2'b00, 3'b111, 2'b00, 2'b00, 7'b00_000_0_1);
    // split write, ALU NZCV=1010: stall, then CV with the enables suppressed
    step(0, 1, 4'hE, 2'b11, 3'b100, 2'b01, 2'b00, 7'b10_100_1_0);
    step(0, 1, 4'hF, 2'b00, 3'b111, 2'b10, 2'b00, 7'b01_000_1_1);
    // LT: N=1 from the shadow, V=0 from the bypassed CV
    step(0, 1, 4'hB, 2'b00, 3'b100, 2'b00, 2'b10, 7'b00_100_1_1);
    // shadows NZ=10 CV=10: GT fails, HI passes
    step(0, 1, 4'hC, 2'b00, 3'b100, 2'b00, 2'b00, 7'b00_000_0_1);
    step(0, 1, 4'h8, 2'b00, 3'b001, 2'b00, 2'b00, 7'b00_001_1_1);
    // CV write to 01, captured during an invalid cycle; CC then passes
    step(0, 1, 4'hE, 2'b01, 3'b000, 2'b00, 2'b00, 7'b01_000_1_1);
    step(0, 0, 4'hE, 2'b11, 3'b100, 2'b00, 2'b01, 7'b00_000_0_1);
    step(0, 1, 4'h3, 2'b00, 3'b100, 2'b00, 2'b11, 7'b00_100_1_1);
    // CV write to 10, then 3 idle cycles with flags_10 moving; CS still sees C=1
    step(0, 1, 4'hE, 2'b01, 3'b000, 2'b00, 2'b01, 7'b01_000_1_1);
    step(0, 0, 4'hE, 2'b00, 3'b000, 2'b00, 2'b10, 7'b00_000_0_1);
    step(0, 0, 4'hE, 2'b00, 3'b000, 2'b00, 2'b01, 7'b00_000_0_1);
    step(0, 0, 4'hE, 2'b00, 3'b000, 2'b00, 2'b00, 7'b00_000_0_1);
    step(0, 1, 4'h2, 2'b00, 3'b010, 2'b00, 2'b00, 7'b00_010_1_1);
    // back-to-back splits: ready 0,1,0,1
    step(0, 1, 4'hE, 2'b11, 3'b011, 2'b00, 2'b00, 7'b10_011_1_0);
    step(0, 0, 4'hE, 2'b00, 3'b111, 2'b00, 2'b00, 7'b01_000_1_1);
    step(0, 1, 4'hE, 2'b11, 3'b100, 2'b00, 2'b00, 7'b10_100_1_0);
    step(0, 1, 4'hF, 2'b11, 3'b111, 2'b00, 2'b00, 7'b01_000_1_1);
    // reset during SPLIT_CV: quiet at once, CV write dropped, shadows cleared
    step(0, 1, 4'hE, 2'b11, 3'b111, 2'b00, 2'b00, 7'b10_111_1_0);
    step(1, 1, 4'hE, 2'b01, 3'b111, 2'b00, 2'b10, 7'b00_000_0_1);
    step(0, 1, 4'h2, 2'b00, 3'b100, 2'b00, 2'b10, 7'b00_000_0_1);
    // never: nothing fires and no split, whatever the flags
    step(0, 1, 4'hF, 2'b11, 3'b111, 2'b11, 2'b11, 7'b00_000_0_1);
    // GE with cleared shadows (N==V) passes
    step(0, 1, 4'hA, 2'b00, 3'b100, 2'b11, 2'b11, 7'b00_100_1_1);

    @(posedge clk);
    #1;
    valid_in = 1'b0;
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution unit that consumes the ALU flags register's outputs and drives its `flag_w` write strobe.
- Evaluates the 4-bit condition field of each instruction against the current N,Z,C,V.
- Gates the instruction's register, memory and PC write enables.
- The flags register clears the half it does not write, so this unit keeps shadow copies of both halves and serializes updates that set both halves.
- Sits between the decoder and the flags register / datapath write ports.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `valid_in`  in  1  decoder presents an instruction this cycle
- `cond`  in  4  condition field
- `flag_w_in`  in  2  requested flag update: bit1 = NZ, bit0 = CV
- `reg_w_in`, `mem_w_in`, `pc_s_in`  in  1 each  ungated write enables from decoder
- `flags_32`  in  2  from flags register: {N,Z}
- `flags_10`  in  2  from flags register: {C,V}
- `flag_w`  out  2  strobe to flags register
- `reg_w`, `mem_w`, `pc_s`  out  1 each  gated enables
- `cond_ex`  out  1  condition passed
- `ready`  out  1  low means the decoder and ALU must hold the current instruction and operands

## Operation
- State: FSM {IDLE, SPLIT_CV}.
- Shadows: `sh_nz[1:0]` and `sh_cv[1:0]`.
- Pending-capture bits: `pend_nz` and `pend_cv`.
- Effective flags:
  - nz = `pend_nz` ? `flags_32` : `sh_nz`
  - cv = `pend_cv` ? `flags_10` : `sh_cv`
  - This is a combinational bypass.
- Condition decode (N,Z,C,V): 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F never (0).
- `cond_ex` = `valid_in` & decode in IDLE; forced 1 in SPLIT_CV.
- IDLE with `cond_ex`=1:
  - `reg_w`/`mem_w`/`pc_s` = inputs.
  - `flag_w_in`=10 → `flag_w`=10.
  - `flag_w_in`=01 → `flag_w`=01.
  - `flag_w_in`=11 → `flag_w`=10, `ready`=0, next state SPLIT_CV.
- SPLIT_CV:
  - `flag_w`=01.
  - `reg_w`/`mem_w`/`pc_s`=0, so each instruction fires its enables exactly once.
  - `ready`=1; next state IDLE.
  - `cond`, `flag_w_in` and the enable inputs are ignored.
- `cond_ex`=0 or `valid_in`=0: all enables and `flag_w` = 0, `ready`=1.
- Capture (clocked):
  - `pend_nz` <= (`flag_w`==10).
  - `pend_cv` <= (`flag_w`==01).
  - When `pend_nz`, `sh_nz` <= `flags_32`.
  - When `pend_cv`, `sh_cv` <= `flags_10`.
  - Cycles where `flag_w`=00 never change shadows, even though the register may overwrite its CV half.
- `flag_w`=11 is never driven.

## Timing
- Reset: state IDLE, shadows 00, pend bits 0.
- Outputs in reset: `flag_w`=00, enables 0, `cond_ex`=0, `ready`=1.
- Enables, `flag_w` and `ready` are combinational from inputs and state: 0-cycle latency.
- The flags register updates at the edge ending cycle T. The shadow captures at the edge ending T+1. An instruction in T+1 sees the new value through the bypass, so there are no bubbles.
- The flag_w=11 split costs exactly 1 stall cycle. The ALU flags must stay stable across both cycles.
- Back-to-back split instructions: IDLE→SPLIT→IDLE→SPLIT, with `ready` pattern 0,1,0,1.
- Reset asserted in SPLIT_CV: immediate return to IDLE. Shadows clear. The pending CV write is dropped.
- Simultaneous pend capture and a new `flag_w` in the same cycle: capture uses the current register outputs. The new pend bit reflects the current `flag_w`.

## Test plan
- Reset, then `valid_in`=1, `cond`=0 (EQ), `flag_w_in`=00 → `cond_ex`=0 (Z=0), `reg_w`=0; `cond`=E → `cond_ex`=1, `reg_w`=`reg_w_in`.
- ALU NZCV=0100 with `flag_w_in`=10, next instr `cond`=0 → `cond_ex`=1 via bypass; third instr EQ still 1 from `sh_nz`=01.
- `flag_w_in`=11, ALU NZCV=1010 → cycle 1: `flag_w`=10, `ready`=0, `reg_w`=1; cycle 2: `flag_w`=01, `reg_w`=0, `ready`=1; then `cond`=B (LT) → `cond_ex`=1 (N=1, V=0).
- Set CV=10 via `flag_w_in`=01, then 3 idle cycles with flags_10 changing → `sh_cv` stays 10; `cond`=2 (CS) → 1.
- Assert `rst` during SPLIT_CV → `flag_w`=00 and `ready`=1 immediately; afterward `cond`=2 → 0.
- `cond`=F with all flags any value → `cond_ex`=0, `mem_w`=0, `pc_s`=0.
